// File: rtl/wb_mast_pkg.sv
// Shared types and constants for the Wishbone master engine.
package wb_mast_pkg;

  localparam int AW_DEF      = 32;
  localparam int DW_DEF      = 32;
  localparam int MAX_LEN_DEF = 16;
  localparam int RTY_MAX_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;

endpackage

// File: rtl/wb_mast_eng.sv
// Wishbone burst master: takes one command (address, direction, byte select,
// beat count, inter-beat gap), runs the beats on the bus, streams write data in
// and read data out, then pulses done with a status code.
// Optional feature: define WB_MAST_RETRY_EN to re-issue a beat on rty (up to
// RTY_MAX times); without it rty terminates the command like err.
module wb_mast_eng
  import wb_mast_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int RTY_MAX = RTY_MAX_DEF,
  localparam int SW     = DW / 8,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_adr,
  input  logic          cmd_we,
  input  logic [SW-1:0] cmd_sel,
  input  logic [LW-1:0] cmd_len,
  input  logic [3:0]    cmd_dly,
  input  logic          wd_valid,
  output logic          wd_ready,
  input  logic [DW-1:0] wd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic [1:0]    status,
  output logic [AW-1:0] adr,
  output logic [DW-1:0] dout,
  input  logic [DW-1:0] din,
  output logic          cyc,
  output logic          stb,
  output logic          we,
  output logic [SW-1:0] sel,
  input  logic          ack,
  input  logic          err,
  input  logic          rty
);

  state_t        state, n_state;
  logic          n_cyc, n_stb, n_we, n_cmd_ready, n_wd_ready, n_rd_valid, n_done;
  logic [AW-1:0] n_adr, c_adr, n_c_adr;
  logic [DW-1:0] n_dout, n_rd_data;
  logic [SW-1:0] n_sel, c_sel, n_c_sel;
  logic [1:0]    n_status, fst;
  logic          c_we, n_c_we, fin;
  logic [LW-1:0] c_len, n_c_len;
  logic [3:0]    c_dly, n_c_dly, gap_cnt, n_gap_cnt;
`ifdef WB_MAST_RETRY_EN
  localparam int RW = (RTY_MAX < 1) ? 1 : $clog2(RTY_MAX + 1);
  logic [RW-1:0] rty_cnt, n_rty_cnt;
`endif

  // Next-state and next-output decode; every output is the registered copy.
  always_comb begin
    n_state     = state;
    n_cyc       = cyc;
    n_stb       = stb;
    n_adr       = adr;
    n_dout      = dout;
    n_sel       = sel;
    n_we        = we;
    n_cmd_ready = 1'b0;
    n_wd_ready  = 1'b0;
    n_done      = 1'b0;
    n_rd_valid  = rd_valid & ~rd_ready;
    n_rd_data   = rd_data;
    n_status    = status;
    n_c_adr     = c_adr;
    n_c_we      = c_we;
    n_c_sel     = c_sel;
    n_c_len     = c_len;
    n_c_dly     = c_dly;
    n_gap_cnt   = gap_cnt;
`ifdef WB_MAST_RETRY_EN
    n_rty_cnt   = rty_cnt;
`endif
    fin         = 1'b0;
    fst         = ST_OK;
    case (state)
      IDLE: begin
        n_cmd_ready = 1'b1;
        if (cmd_valid && cmd_ready) begin
          n_c_adr     = cmd_adr;
          n_c_we      = cmd_we;
          n_c_sel     = cmd_sel;
          n_c_len     = cmd_len;
          n_c_dly     = cmd_dly;
          n_gap_cnt   = cmd_dly;
          n_cyc       = (cmd_len != '0);
          n_cmd_ready = 1'b0;
          n_state     = GAP;
        end
      end
      GAP: begin
        if (c_len == '0) begin
          fin = 1'b1;
        end else if (gap_cnt != 4'd0) begin
          n_gap_cnt = gap_cnt - 4'd1;
        // wd_ready high means the current word is being consumed this cycle,
        // so the next word is not on wd_data yet.
        end else if (c_we ? (wd_valid && !wd_ready) : !rd_valid) begin
          n_state = REQ;
          n_stb   = 1'b1;
          n_adr   = c_adr;
          n_sel   = c_sel;
          n_we    = c_we;
          n_dout  = c_we ? wd_data : '0;
`ifdef WB_MAST_RETRY_EN
          n_rty_cnt = '0;
`endif
        end
      end
      REQ: begin
        if (!stb) begin
          // one idle cycle after a retry, then re-issue the same beat
          n_stb = 1'b1;
        end else if (err) begin
          fin = 1'b1;
          fst = ST_ERR;
        end else if (ack) begin
          n_stb   = 1'b0;
          n_c_adr = c_adr + AW'(SW);
          n_c_len = c_len - 1'b1;
          if (c_we) n_wd_ready = 1'b1;
          else begin
            n_rd_valid = 1'b1;
            n_rd_data  = din;
          end
          if (c_len == LW'(1)) fin = 1'b1;
          else begin
            n_state   = GAP;
            n_gap_cnt = c_dly;
          end
        end else if (rty) begin
`ifdef WB_MAST_RETRY_EN
          if (rty_cnt == RW'(RTY_MAX)) begin
            fin = 1'b1;
            fst = ST_RTY;
          end else begin
            n_rty_cnt = rty_cnt + 1'b1;
            n_stb     = 1'b0;
          end
`else
          fin = 1'b1;
          fst = ST_ERR;
`endif
        end
      end
      DONE: begin
        n_state     = IDLE;
        n_cmd_ready = 1'b1;
      end
      default: n_state = IDLE;
    endcase
    if (fin) begin
      n_state  = DONE;
      n_cyc    = 1'b0;
      n_stb    = 1'b0;
      n_done   = 1'b1;
      n_status = fst;
    end
    // bus qualifiers are only non-zero while a beat is in flight
    if (n_state != REQ) begin
      n_adr  = '0;
      n_dout = '0;
      n_sel  = '0;
      n_we   = 1'b0;
    end
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      adr       <= '0;
      dout      <= '0;
      sel       <= '0;
      we        <= 1'b0;
      cmd_ready <= 1'b1;
      wd_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      status    <= ST_OK;
      c_adr     <= '0;
      c_we      <= 1'b0;
      c_sel     <= '0;
      c_len     <= '0;
      c_dly     <= '0;
      gap_cnt   <= '0;
`ifdef WB_MAST_RETRY_EN
      rty_cnt   <= '0;
`endif
    end else begin
      state     <= n_state;
      cyc       <= n_cyc;
      stb       <= n_stb;
      adr       <= n_adr;
      dout      <= n_dout;
      sel       <= n_sel;
      we        <= n_we;
      cmd_ready <= n_cmd_ready;
      wd_ready  <= n_wd_ready;
      rd_valid  <= n_rd_valid;
      rd_data   <= n_rd_data;
      done      <= n_done;
      status    <= n_status;
      c_adr     <= n_c_adr;
      c_we      <= n_c_we;
      c_sel     <= n_c_sel;
      c_len     <= n_c_len;
      c_dly     <= n_c_dly;
      gap_cnt   <= n_gap_cnt;
`ifdef WB_MAST_RETRY_EN
      rty_cnt   <= n_rty_cnt;
`endif
    end
  end

endmodule

// File: tb/tb_wb_mast_eng.sv
// Bench for wb_mast_eng: scripted Wishbone slave, write-data source and
// read-data sink, checked against a beat-level model of each command.
module tb_wb_mast_eng;
  import wb_mast_pkg::*;

  localparam int AW = 32, DW = 32, SW = 4, MAX_LEN = 16, LW = 5, RTY_MAX = 3;

  typedef struct {
    logic [2:0] m;   // {err, ack, rty}
    int         ws;  // wait cycles before responding
  } resp_t;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [3:0]    cmd_dly = '0;
  logic          cmd_ready, wd_ready, rd_valid, done, cyc, stb, we;
  logic          wd_valid = 1'b0, rd_ready = 1'b1, ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic [DW-1:0] wd_data = '0, din = '0, rd_data, dout;
  logic [1:0]    status;
  logic [AW-1:0] adr;
  logic [SW-1:0] sel;

  wb_mast_eng #(.AW(AW), .DW(DW), .MAX_LEN(MAX_LEN), .RTY_MAX(RTY_MAX)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
    .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_len(cmd_len), .cmd_dly(cmd_dly),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .status(status), .adr(adr), .dout(dout), .din(din),
    .cyc(cyc), .stb(stb), .we(we), .sel(sel), .ack(ack), .err(err), .rty(rty));

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk = 0, n_fail = 0;

  // command set-up, written only by the stimulus
  logic [DW-1:0] wbuf [MAX_LEN];
  resp_t         scr_buf [64];
  int            wcount = 0, scount = 0, rd_hold = 0, cmd_id = 0;
  logic [DW-1:0] salt = '0;

  // observations, written only by the monitor
  logic [AW-1:0] iss_adr[$];
  logic [DW-1:0] iss_dout[$];
  logic [SW-1:0] iss_sel[$];
  logic          iss_we[$];
  int            iss_cyc[$];
  logic [DW-1:0] rq[$];
  int            seen_id = 0, sptr = 0, wptr = 0, held = 0, wcnt = 0;
  int            wd_pulses = 0, done_cnt = 0, done_cyc = 0, last_resp = 0, rd_busy = 0;
  bit            have = 0, wd_take = 0;
  logic          done_bus = 1'b0;
  logic [1:0]    done_st = '0;
  resp_t         cur;

  function automatic resp_t R(input logic [2:0] m, input int ws);
    resp_t r;
    r.m = m;
    r.ws = ws;
    return r;
  endfunction

  function automatic logic [DW-1:0] rmem(input logic [AW-1:0] a);
    return a ^ salt ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave, write source, read sink and done monitor; inputs change mid-cycle.
  always @(negedge clk) begin
    if (cmd_id != seen_id) begin
      seen_id = cmd_id;
      iss_adr.delete(); iss_dout.delete(); iss_sel.delete(); iss_we.delete(); iss_cyc.delete();
      rq.delete();
      sptr = 0; wptr = 0; held = 0; wd_take = 0; have = 0;
      wd_pulses = 0; done_cnt = 0; rd_busy = 0;
    end
    ack = 1'b0; err = 1'b0; rty = 1'b0;
    if (rst) begin
      have = 0;
      wd_take = 0;
    end else begin
      if (cyc && stb) begin
        if (!have) begin
          have = 1;
          wcnt = 0;
          if (sptr < scount) begin cur = scr_buf[sptr]; sptr++; end
          else cur = R(3'b010, 0);
          iss_adr.push_back(adr); iss_dout.push_back(dout);
          iss_sel.push_back(sel); iss_we.push_back(we); iss_cyc.push_back(cyc_n);
          if (!we && rd_valid) rd_busy++;
        end
        if (wcnt >= cur.ws) begin
          err = cur.m[2]; ack = cur.m[1]; rty = cur.m[0];
          din = rmem(adr);
          have = 0;
          last_resp = cyc_n;
        end else wcnt++;
      end else have = 0;
      if (wd_take) wptr++;
      wd_valid = (wptr < wcount);
      wd_data  = wd_valid ? wbuf[wptr] : '0;
      wd_take  = wd_valid && wd_ready;
      if (wd_ready) wd_pulses++;
      if (rd_valid && rq.size() == 0 && held < rd_hold) begin
        rd_ready = 1'b0;
        held++;
      end else rd_ready = 1'b1;
      if (rd_valid && rd_ready) rq.push_back(rd_data);
      if (done) begin
        done_cnt++;
        done_st  = status;
        done_cyc = cyc_n;
        done_bus = cyc | stb;
      end
    end
  end

  task automatic run_cmd(input string tag, input logic [AW-1:0] a0, input logic w,
                         input logic [SW-1:0] s, input int len, input int dly, input int rdh);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$], er[$];
    logic [1:0]    est;
    logic [AW-1:0] a;
    logic [2:0]    m;
    int ep, beat, r, i, hs, t, n;
    for (int k = 0; k < len; k++) wbuf[k] = $urandom;
    wcount  = w ? len : 0;
    rd_hold = rdh;
    // beat-level reference: each bus issue consumes one scripted response
    est = ST_OK; ep = 0; beat = 0; r = 0; i = 0; a = a0;
    while (beat < len) begin
      m = (i < scount) ? scr_buf[i].m : 3'b010;
      i++;
      ea.push_back(a);
      ed.push_back(w ? wbuf[beat] : '0);
      if (m[2]) begin est = ST_ERR; break; end
      else if (m[1]) begin
        if (w) ep++; else er.push_back(rmem(a));
        a = a + SW; beat++; r = 0;
      end else begin
`ifdef WB_MAST_RETRY_EN
        if (r == RTY_MAX) begin est = ST_RTY; break; end
        r++;
`else
        est = ST_ERR; break;
`endif
      end
    end
    cmd_id++;
    @(negedge clk);
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    cmd_adr = a0; cmd_we = w; cmd_sel = s; cmd_len = LW'(len); cmd_dly = 4'(dly);
    cmd_valid = 1'b1;
    hs = cyc_n;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, "_busy_no_ready"}, cmd_ready, 1'b0);
    t = 0;
    while (done_cnt == 0 && t < 3000) begin @(negedge clk); t++; end
    chk({tag, "_done_seen"}, (done_cnt > 0), 1'b1);
    repeat (rdh + 4) @(negedge clk);
    chk({tag, "_status"}, done_st, est);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_done_bus_low"}, done_bus, 1'b0);
    chk({tag, "_n_issue"}, iss_adr.size(), ea.size());
    n = (iss_adr.size() < ea.size()) ? iss_adr.size() : ea.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_adr%0d", tag, k), iss_adr[k], ea[k]);
      chk($sformatf("%s_dout%0d", tag, k), iss_dout[k], ed[k]);
      chk($sformatf("%s_sel_we%0d", tag, k), {iss_sel[k], iss_we[k]}, {s, w});
    end
    chk({tag, "_wd_pulses"}, wd_pulses, ep);
    chk({tag, "_rd_count"}, rq.size(), er.size());
    n = (rq.size() < er.size()) ? rq.size() : er.size();
    for (int k = 0; k < n; k++) chk($sformatf("%s_rd%0d", tag, k), rq[k], er[k]);
    chk({tag, "_rd_wait_free"}, rd_busy, 0);
    if (len > 0) begin
      if (iss_cyc.size() > 0) chk({tag, "_first_lat"}, iss_cyc[0] - hs, dly + 2);
      chk({tag, "_done_after_resp"}, done_cyc - last_resp, 1);
    end else begin
      chk({tag, "_len0_lat"}, done_cyc - hs, 2);
    end
    chk({tag, "_idle_adr"}, adr, '0);
    chk({tag, "_idle_bus"}, {cyc, stb, we, sel, dout}, '0);
    chk({tag, "_idle_ready"}, cmd_ready, 1'b1);
    scount = 0;
  endtask

  initial begin
    int t, len, we_r;
    salt = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_bus", {cyc, stb, we, sel, dout}, '0);
    chk("rst_adr", adr, '0);
    chk("rst_flags", {rd_valid, wd_ready, done, status}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);

    // four writes, one wait state each
    for (int k = 0; k < 4; k++) scr_buf[k] = R(3'b010, 1);
    scount = 4;
    run_cmd("wr4", 32'h100, 1'b1, 4'hF, 4, 0, 0);

    // three reads with a gap, first word held back by the sink
    run_cmd("rd3", 32'h200, 1'b0, 4'hF, 3, 2, 5);

    // error on the second of four writes
    scr_buf[0] = R(3'b010, 0); scr_buf[1] = R(3'b100, 1); scount = 2;
    run_cmd("wr_err", 32'h300, 1'b1, 4'h3, 4, 1, 0);

    // retry twice then ack
    scr_buf[0] = R(3'b001, 0); scr_buf[1] = R(3'b001, 1); scr_buf[2] = R(3'b010, 0); scount = 3;
    run_cmd("rty2", 32'h400, 1'b1, 4'hF, 2, 0, 0);

    // retry on every issue
    for (int k = 0; k < 6; k++) scr_buf[k] = R(3'b001, 0);
    scount = 6;
    run_cmd("rty_all", 32'h500, 1'b0, 4'hC, 2, 0, 0);

    // simultaneous responses: err beats ack beats rty
    scr_buf[0] = R(3'b011, 0); scr_buf[1] = R(3'b111, 0); scount = 2;
    run_cmd("prio", 32'h600, 1'b0, 4'hF, 3, 0, 1);

    // address wrap at the top of the space
    run_cmd("wrap", 32'hFFFF_FFFC, 1'b0, 4'hF, 2, 0, 0);

    // zero-length command
    run_cmd("len0", 32'h700, 1'b1, 4'hF, 0, 5, 0);

    // reset in the middle of a beat
    wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'h1234_5678; wcount = 2;
    scr_buf[0] = R(3'b010, 30); scount = 1;
    cmd_id++;
    @(negedge clk);
    cmd_adr = 32'h40; cmd_we = 1'b1; cmd_sel = 4'hF; cmd_len = 5'd2; cmd_dly = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!stb && t < 50) begin @(negedge clk); t++; end
    chk("mid_stb_seen", stb, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc_stb", {cyc, stb}, 2'b00);
    chk("mid_rst_bus", {adr, dout}, '0);
    wcount = 0; scount = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_status", {status, done, wd_ready}, '0);
    run_cmd("post_rst", 32'h80, 1'b1, 4'hF, 2, 1, 0);

    // randomized commands
    for (int n = 0; n < 25; n++) begin
      len  = $urandom_range(0, 6);
      we_r = $urandom_range(0, 1);
      scount = len * (RTY_MAX + 2);
      for (int k = 0; k < scount; k++)
        scr_buf[k] = R(($urandom_range(0, 9) < 7) ? 3'b010 : 3'($urandom_range(1, 7)),
                       $urandom_range(0, 2));
      run_cmd($sformatf("rnd%0d", n), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
              we_r[0], 4'($urandom_range(1, 15)), len, $urandom_range(0, 3),
              $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
